trace_sched: RTL and testbench

TRACE_SCHED -- requirements
Module: trace_sched

---
 rtl/trace_sched_pkg.sv | 27 ++
 rtl/trace_sched.sv | 133 +++++++++++++
 tb/tb_trace_sched.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_sched_pkg.sv
// Shared display-timing package: frame geometry defaults, field widths,
// the trace scheduler state encoding and the next-row helper.
package trace_sched_pkg;

    localparam int H_TOTAL_DEF   = 800;
    localparam int V_TOTAL_DEF   = 525;
    localparam int V_VISIBLE_DEF = 480;

    localparam int POS_W  = 10;
    localparam int SIZE_W = 11;
    localparam int MISS_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } trace_state_t;

    // Row that follows pos in a frame of total lines (wraps to row 0).
    function automatic logic [POS_W-1:0] calc_next_row(input logic [POS_W-1:0] pos,
                                                       input int total);
        if (int'(pos) == total - 1) begin
            return '0;
        end
        return pos + 1'b1;
    endfunction

endpackage

// File: rtl/trace_sched.sv
// Ray-trace scheduler: one trace request per visible line, issued at the
// start of the line for the following row. Results are double-buffered
// (pending for the next line, active for the line on screen) and swapped
// at the last clock of each line. Missed deadlines are counted.
//
// Handshake: trace_req rises one cycle after hpos = 0 and stays high with
// trace_row stable until the cycle after trace_done is seen high (or the
// line ends). trace_done/trace_side/trace_size are sampled only while
// trace_req is high; there is no backpressure on the tracer.
module trace_sched
    import trace_sched_pkg::*;
#(
    parameter int H_TOTAL   = H_TOTAL_DEF,
    parameter int V_TOTAL   = V_TOTAL_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [POS_W-1:0]  hpos,
    input  logic [POS_W-1:0]  vpos,
    input  logic              enable,
    output logic              trace_req,
    output logic [POS_W-1:0]  trace_row,
    input  logic              trace_done,
    input  logic              trace_side,
    input  logic [SIZE_W-1:0] trace_size,
    output logic              row_side,
    output logic [SIZE_W-1:0] row_size,
    output logic              row_valid,
    output logic [MISS_W-1:0] miss_count,
    output trace_state_t      dbg_state
);

    trace_state_t      state_q;
    logic              req_q;
    logic [POS_W-1:0]  row_q;
    logic              pend_side_q;
    logic [SIZE_W-1:0] pend_size_q;
    logic              pend_valid_q;
    logic              act_side_q;
    logic [SIZE_W-1:0] act_size_q;
    logic              act_valid_q;
    logic [MISS_W-1:0] miss_q;

    logic [POS_W-1:0]  next_row;
    logic              line_end;
    logic              next_visible;
    logic              start_req;
    logic              take_result;
    logic [MISS_W-1:0] miss_d;

    // Line timing decode and the per-cycle request/capture decisions.
    always_comb begin
        next_row     = calc_next_row(vpos, V_TOTAL);
        line_end     = (hpos == POS_W'(H_TOTAL - 1));
        next_visible = (int'(next_row) < V_VISIBLE);
        start_req    = (state_q == ST_IDLE) && (hpos == '0) && enable && next_visible;
        take_result  = (state_q == ST_REQ) && trace_done;
        miss_d       = (miss_q == '1) ? miss_q : miss_q + 1'b1;
    end

    // Request FSM, result double-buffer and saturating miss counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            row_q        <= '0;
            pend_side_q  <= 1'b0;
            pend_size_q  <= '0;
            pend_valid_q <= 1'b0;
            act_side_q   <= 1'b0;
            act_size_q   <= '0;
            act_valid_q  <= 1'b0;
            miss_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        row_q   <= next_row;
                    end
                end
                ST_REQ: begin
                    // A result or the end of the line both close the request;
                    // a late tracer is simply abandoned.
                    if (trace_done || line_end) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase

            if (line_end) begin
                if (take_result) begin
                    // Result arrived on the very last clock: bypass pending.
                    act_side_q  <= trace_side;
                    act_size_q  <= trace_size;
                    act_valid_q <= 1'b1;
                end else if (pend_valid_q) begin
                    act_side_q  <= pend_side_q;
                    act_size_q  <= pend_size_q;
                    act_valid_q <= 1'b1;
                end else begin
                    act_side_q  <= 1'b0;
                    act_size_q  <= '0;
                    act_valid_q <= 1'b0;
                end
                pend_valid_q <= 1'b0;
                if (next_visible && !take_result && !pend_valid_q) begin
                    miss_q <= miss_d;
                end
            end else if (take_result) begin
                pend_side_q  <= trace_side;
                pend_size_q  <= trace_size;
                pend_valid_q <= 1'b1;
            end
        end
    end

    assign trace_req  = req_q;
    assign trace_row  = row_q;
    assign row_side   = act_side_q;
    assign row_size   = act_valid_q ? act_size_q : '0;
    assign row_valid  = act_valid_q;
    assign miss_count = miss_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_trace_sched.sv
// Bench for trace_sched: a line driver plays hpos/vpos/tracer responses,
// directed vectors push the expected request row, request duration and
// end-of-line result into queues, and a monitor pops and compares them.
module tb_trace_sched;
    import trace_sched_pkg::*;

    localparam int TB_H = 128;
    localparam int TB_V = 525;
    localparam int TB_VIS = 480;

    logic              clk;
    logic              reset_n;
    logic [POS_W-1:0]  hpos;
    logic [POS_W-1:0]  vpos;
    logic              enable;
    logic              trace_req;
    logic [POS_W-1:0]  trace_row;
    logic              trace_done;
    logic              trace_side;
    logic [SIZE_W-1:0] trace_size;
    logic              row_side;
    logic [SIZE_W-1:0] row_size;
    logic              row_valid;
    logic [MISS_W-1:0] miss_count;
    trace_state_t      dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [POS_W-1:0] exp_row_q[$];
    logic [15:0]      exp_dur_q[$];
    logic [20:0]      exp_line_q[$];

    logic le_flag = 1'b0;

    trace_sched #(
        .H_TOTAL  (TB_H),
        .V_TOTAL  (TB_V),
        .V_VISIBLE(TB_VIS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hpos      (hpos),
        .vpos      (vpos),
        .enable    (enable),
        .trace_req (trace_req),
        .trace_row (trace_row),
        .trace_done(trace_done),
        .trace_side(trace_side),
        .trace_size(trace_size),
        .row_side  (row_side),
        .row_size  (row_size),
        .row_valid (row_valid),
        .miss_count(miss_count),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: DUT event with no expectation queued at %0t", name, $time);
    endtask

    task automatic exp_req(input logic [POS_W-1:0] row, input int dur);
        exp_row_q.push_back(row);
        exp_dur_q.push_back(16'(dur));
    endtask

    task automatic exp_line(input logic v, input logic s, input logic [SIZE_W-1:0] sz,
                            input logic [MISS_W-1:0] m);
        exp_line_q.push_back({v, s, sz, m});
    endtask

    // ---------------- driver ----------------
    task automatic drive_span(input int v, input int h_from, input int h_to, input int done_at,
                              input logic side, input logic [SIZE_W-1:0] size, input int en_off_at);
        for (int h = h_from; h <= h_to; h++) begin
            hpos = POS_W'(h);
            vpos = POS_W'(v);
            if (h == en_off_at) enable = 1'b0;
            if (h == done_at) begin
                trace_done = 1'b1;
                trace_side = side;
                trace_size = size;
            end else begin
                trace_done = 1'b0;
                trace_side = ~side;
                trace_size = 11'h5a5;
            end
            @(posedge clk);
            #1;
        end
        trace_done = 1'b0;
    endtask

    task automatic drive_line(input int v, input int done_at, input logic side,
                              input logic [SIZE_W-1:0] size);
        drive_span(v, 0, TB_H - 1, done_at, side, size, -1);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            le_flag = reset_n && (hpos == POS_W'(TB_H - 1));
        end
    end

    initial begin
        logic             was_req;
        int               req_cnt;
        logic [POS_W-1:0] cur_row;
        logic [20:0]      exp_l;
        was_req = 1'b0;
        req_cnt = 0;
        cur_row = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                was_req = 1'b0;
                req_cnt = 0;
            end else begin
                if (trace_req && !was_req) begin
                    if (exp_row_q.size() == 0) begin
                        unexpected("req_rise");
                    end else begin
                        cur_row = exp_row_q.pop_front();
                        check("req_row", 32'(trace_row), 32'(cur_row));
                    end
                    req_cnt = 1;
                end else if (trace_req) begin
                    req_cnt++;
                end
                if (!trace_req && was_req) begin
                    if (exp_dur_q.size() == 0) begin
                        unexpected("req_fall");
                    end else begin
                        check("req_cycles", 32'(req_cnt), 32'(exp_dur_q.pop_front()));
                    end
                    check("row_hold", 32'(trace_row), 32'(cur_row));
                end
                was_req = trace_req;
                if (le_flag) begin
                    if (exp_line_q.size() == 0) begin
                        unexpected("line_end");
                    end else begin
                        exp_l = exp_line_q.pop_front();
                        check("line_result", 32'({row_valid, row_side, row_size, miss_count}),
                              32'(exp_l));
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: stimulus did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int m;
        reset_n    = 1'b0;
        hpos       = POS_W'(1);
        vpos       = POS_W'(8);
        enable     = 1'b1;
        trace_done = 1'b0;
        trace_side = 1'b0;
        trace_size = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(trace_req), 32'd0);
        check("rst_row", 32'(trace_row), 32'd0);
        check("rst_valid", 32'(row_valid), 32'd0);
        check("rst_miss", 32'(miss_count), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset_n = 1'b1;

        // Released mid-line: no request until the next hpos = 0; the next
        // row (9) is visible and nothing was captured, so one miss.
        exp_line(1'b0, 1'b0, 11'd0, 8'd1);
        drive_span(8, 1, TB_H - 1, -1, 1'b0, 11'd0, -1);

        // Tracer answers after 100 cycles.
        exp_req(10'd10, 100);
        exp_line(1'b1, 1'b1, 11'd300, 8'd1);
        drive_line(9, 100, 1'b1, 11'd300);

        // Tracer never answers: abort at the last clock, miss counted.
        exp_req(10'd11, TB_H - 1);
        exp_line(1'b0, 1'b0, 11'd0, 8'd2);
        drive_line(10, -1, 1'b0, 11'd0);

        // Result on the last clock of the line: direct load, no miss.
        exp_req(10'd12, TB_H - 1);
        exp_line(1'b1, 1'b0, 11'd513, 8'd2);
        drive_line(11, TB_H - 1, 1'b0, 11'd513);

        // Max size, then a valid zero size.
        exp_req(10'd13, 5);
        exp_line(1'b1, 1'b1, 11'd2047, 8'd2);
        drive_line(12, 5, 1'b1, 11'd2047);
        exp_req(10'd14, 60);
        exp_line(1'b1, 1'b0, 11'd0, 8'd2);
        drive_line(13, 60, 1'b0, 11'd0);

        // Enable dropped mid-request: completes; next line issues nothing.
        exp_req(10'd15, 90);
        exp_line(1'b1, 1'b1, 11'd77, 8'd2);
        drive_span(14, 0, TB_H - 1, 90, 1'b1, 11'd77, 40);
        exp_line(1'b0, 1'b0, 11'd0, 8'd3);
        drive_line(15, -1, 1'b0, 11'd0);
        enable = 1'b1;

        // Bottom of the frame and vertical wrap.
        exp_req(10'd479, 30);
        exp_line(1'b1, 1'b1, 11'd10, 8'd3);
        drive_line(478, 30, 1'b1, 11'd10);
        for (int v = 479; v <= 523; v++) begin
            exp_line(1'b0, 1'b0, 11'd0, 8'd3);
            drive_line(v, 10, 1'b1, 11'd44);
        end
        exp_req(10'd0, 20);
        exp_line(1'b1, 1'b0, 11'd55, 8'd3);
        drive_line(524, 20, 1'b0, 11'd55);

        // 300 consecutive misses: counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            m = 3 + i + 1;
            if (m > 255) m = 255;
            exp_req(POS_W'(i + 1), TB_H - 1);
            exp_line(1'b0, 1'b0, 11'd0, 8'(m));
            drive_line(i, -1, 1'b0, 11'd0);
        end
        exp_req(10'd301, 10);
        exp_line(1'b1, 1'b1, 11'd99, 8'd255);
        drive_line(300, 10, 1'b1, 11'd99);

        // Asynchronous reset while a request is in flight.
        exp_row_q.push_back(10'd302);
        drive_span(301, 0, 20, -1, 1'b0, 11'd0, -1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_req", 32'(trace_req), 32'd0);
        check("arst_row", 32'(trace_row), 32'd0);
        check("arst_side", 32'(row_side), 32'd0);
        check("arst_size", 32'(row_size), 32'd0);
        check("arst_valid", 32'(row_valid), 32'd0);
        check("arst_miss", 32'(miss_count), 32'd0);
        check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (3) @(posedge clk);
        #1;
        hpos = POS_W'(21);
        reset_n = 1'b1;
        exp_line(1'b0, 1'b0, 11'd0, 8'd1);
        drive_span(301, 21, TB_H - 1, -1, 1'b0, 11'd0, -1);
        exp_req(10'd303, 50);
        exp_line(1'b1, 1'b1, 11'd123, 8'd1);
        drive_line(302, 50, 1'b1, 11'd123);

        // Drain and report anything the DUT never produced.
        hpos = POS_W'(5);
        repeat (3) @(posedge clk);
        #1;
        while (exp_row_q.size() > 0) begin
            n_err++;
            $display("FAIL req_row: no request seen, expected row %0d", exp_row_q.pop_front());
        end
        while (exp_dur_q.size() > 0) begin
            n_err++;
            $display("FAIL req_cycles: request never ended, expected %0d cycles",
                     exp_dur_q.pop_front());
        end
        while (exp_line_q.size() > 0) begin
            n_err++;
            $display("FAIL line_result: line end never seen, expected 0x%0h",
                     exp_line_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
